// File: rtl/equiv_sweep_ctrl.sv
// Exhaustive equivalence sweep: drives every N-bit vector to two implementations,
// compares their outputs after a settle delay and records the f_min truth table.
module equiv_sweep_ctrl #(
    parameter int N      = 4,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               f_min,
    input  logic               f_max,
    output logic [N-1:0]       vec,
    output logic               busy,
    output logic               done,
    output logic               match,
    output logic [N:0]         mism_cnt,
    output logic [N-1:0]       first_bad,
    output logic [2**N-1:0]    table_min
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [N-1:0] VEC_LAST    = '1;
    localparam logic [N:0]   CNT_MAX     = (N+1)'(2**N);
    localparam logic [3:0]   SETTLE_LAST = 4'((SETTLE > 0) ? SETTLE - 1 : 0);

    state_t          stateReg;
    state_t          stateNext;
    logic [N-1:0]    vecReg;
    logic [3:0]      settleCntReg;
    logic            matchReg;
    logic [N:0]      mismCntReg;
    logic [N-1:0]    firstBadReg;
    logic [2**N-1:0] tableReg;

    logic            clearRes;
    logic            takeSample;
    logic            mismatch;

    assign clearRes   = (stateReg == S_IDLE) && start;
    assign takeSample = (stateReg == S_SAMPLE) && !abort;
    assign mismatch   = f_min ^ f_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg <= S_IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            S_IDLE: begin
                // start outranks abort here because abort is never looked at in IDLE
                if (start) begin
                    stateNext = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    stateNext = S_IDLE;
                end else if (settleCntReg == SETTLE_LAST) begin
                    stateNext = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (abort) begin
                    stateNext = S_IDLE;
                end else if (vecReg == VEC_LAST) begin
                    stateNext = S_DONE;
                end else begin
                    stateNext = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
                end
            end
            S_DONE: begin
                stateNext = S_IDLE;
            end
            default: begin
                stateNext = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vecReg       <= '0;
            settleCntReg <= '0;
            matchReg     <= 1'b1;
            mismCntReg   <= '0;
            firstBadReg  <= '0;
        end else begin
            case (stateReg)
                S_IDLE: begin
                    if (start) begin
                        vecReg       <= '0;
                        settleCntReg <= '0;
                        matchReg     <= 1'b1;
                        mismCntReg   <= '0;
                        firstBadReg  <= '0;
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        vecReg <= '0;
                    end else if (settleCntReg == SETTLE_LAST) begin
                        settleCntReg <= '0;
                    end else begin
                        settleCntReg <= settleCntReg + 4'd1;
                    end
                end
                S_SAMPLE: begin
                    if (abort) begin
                        vecReg <= '0;
                    end else begin
                        if (mismatch) begin
                            matchReg <= 1'b0;
                            if (mismCntReg != CNT_MAX) begin
                                mismCntReg <= mismCntReg + 1'b1;
                            end
                            // matchReg still high means this is the first mismatch of the sweep
                            if (matchReg) begin
                                firstBadReg <= vecReg;
                            end
                        end
                        if (vecReg != VEC_LAST) begin
                            vecReg <= vecReg + 1'b1;
                        end
                        settleCntReg <= '0;
                    end
                end
                S_DONE: begin
                    vecReg <= '0;
                end
                default: begin
                    vecReg <= '0;
                end
            endcase
        end
    end

    // One flop per truth-table entry, written only when its own vector is sampled
    for (genvar gi = 0; gi < 2**N; gi++) begin : g_table
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                tableReg[gi] <= 1'b0;
            end else if (clearRes) begin
                tableReg[gi] <= 1'b0;
            end else if (takeSample && (vecReg == N'(gi))) begin
                tableReg[gi] <= f_min;
            end
        end
    end

    assign vec       = vecReg;
    assign busy      = (stateReg != S_IDLE);
    assign done      = (stateReg == S_DONE);
    assign match     = matchReg;
    assign mism_cnt  = mismCntReg;
    assign first_bad = firstBadReg;
    assign table_min = tableReg;

endmodule

// File: tb/tb_equiv_sweep_ctrl.sv
// Directed bench for equiv_sweep_ctrl: table of full sweeps on an N=4/SETTLE=1
// instance plus hand sequences for abort, reset and the SETTLE=0 / N=3 variants.
module tb_equiv_sweep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] startV = '0;
    logic [2:0] abortV = '0;
    logic [2:0] rstnV  = '0;
    logic [2:0] busyV;
    logic [2:0] doneV;

    // instance A: N=4, SETTLE=1
    int          aMode = 0;
    logic        aFmin, aFmax, aMatch;
    logic [3:0]  aVec, aFirst;
    logic [4:0]  aCnt;
    logic [15:0] aTable;
    // instance B: N=4, SETTLE=0
    logic        bFmin, bFmax, bMatch;
    logic [3:0]  bVec, bFirst;
    logic [4:0]  bCnt;
    logic [15:0] bTable;
    // instance C: N=3, SETTLE=2
    logic        cFmin, cFmax, cMatch;
    logic [2:0]  cVec, cFirst;
    logic [3:0]  cCnt;
    logic [7:0]  cTable;

    always_comb begin
        aFmin = 1'b0;
        aFmax = 1'b0;
        case (aMode)
            0: begin aFmin = aVec[0]; aFmax = aVec[0];  end
            1: begin aFmin = 1'b1;    aFmax = 1'b1;     end
            2: begin aFmin = aVec[0]; aFmax = ~aVec[0]; end
            default: begin aFmin = aVec[3]; aFmax = aVec[3] & ~aVec[2]; end
        endcase
    end
    assign bFmin = bVec[1];
    assign bFmax = bVec[1] ^ ((bVec == 4'd5) || (bVec == 4'd11));
    assign cFmin = 1'b1;
    assign cFmax = 1'b1;

    equiv_sweep_ctrl #(.N(4), .SETTLE(1)) dutA (
        .clk(clk), .rst_n(rstnV[0]), .start(startV[0]), .abort(abortV[0]),
        .f_min(aFmin), .f_max(aFmax), .vec(aVec), .busy(busyV[0]), .done(doneV[0]),
        .match(aMatch), .mism_cnt(aCnt), .first_bad(aFirst), .table_min(aTable));

    equiv_sweep_ctrl #(.N(4), .SETTLE(0)) dutB (
        .clk(clk), .rst_n(rstnV[1]), .start(startV[1]), .abort(abortV[1]),
        .f_min(bFmin), .f_max(bFmax), .vec(bVec), .busy(busyV[1]), .done(doneV[1]),
        .match(bMatch), .mism_cnt(bCnt), .first_bad(bFirst), .table_min(bTable));

    equiv_sweep_ctrl #(.N(3), .SETTLE(2)) dutC (
        .clk(clk), .rst_n(rstnV[2]), .start(startV[2]), .abort(abortV[2]),
        .f_min(cFmin), .f_max(cFmax), .vec(cVec), .busy(busyV[2]), .done(doneV[2]),
        .match(cMatch), .mism_cnt(cCnt), .first_bad(cFirst), .table_min(cTable));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Start a sweep on instance k and follow it until busy drops; cycle 1 is the
    // cycle right after the edge that samples start.
    task automatic runSweep(input int k, input bit withAbort, input int againAt,
                            input int abortAt, output int doneCyc, output int dones);
        int cyc;
        startV[k] = 1'b1;
        abortV[k] = withAbort;
        @(posedge clk); #1;
        startV[k] = 1'b0;
        abortV[k] = 1'b0;
        cyc = 1;
        doneCyc = -1;
        dones = 0;
        while (cyc < 200) begin
            if (doneV[k]) begin
                dones++;
                if (doneCyc < 0) doneCyc = cyc;
            end
            if (!busyV[k]) break;
            startV[k] = (cyc == againAt);
            abortV[k] = (cyc == abortAt);
            @(posedge clk); #1;
            cyc++;
        end
        startV[k] = 1'b0;
        abortV[k] = 1'b0;
    endtask

    typedef struct {
        int          mode;
        bit          withAbort;
        int          abortAt;
        int          expCyc;
        bit          expMatch;
        int          expCnt;
        int          expFirst;
        logic [15:0] expTable;
    } rec_t;

    rec_t recs[4];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dc, dn, extra;

        recs[0] = '{0, 1'b0, 0,  33, 1'b1, 0,  0,  16'hAAAA};
        recs[1] = '{1, 1'b1, 0,  33, 1'b1, 0,  0,  16'hFFFF}; // start+abort together
        recs[2] = '{2, 1'b0, 0,  33, 1'b0, 16, 0,  16'hAAAA}; // every vector mismatches
        recs[3] = '{3, 1'b0, 33, 33, 1'b0, 4,  12, 16'hFF00}; // abort while in DONE

        // reset values
        #12;
        chk("rst_busy", busyV[0], 0);
        chk("rst_done", doneV[0], 0);
        chk("rst_vec", aVec, 0);
        chk("rst_match", aMatch, 1);
        chk("rst_cnt", aCnt, 0);
        chk("rst_first", aFirst, 0);
        chk("rst_table", aTable, 0);
        $display("reset: busy=%0b vec=%0h match=%0b cnt=%0d table=%h", busyV[0], aVec, aMatch, aCnt, aTable);
        @(negedge clk);
        rstnV = '1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            aMode = recs[i].mode;
            runSweep(0, recs[i].withAbort, 0, recs[i].abortAt, dc, dn);
            chk($sformatf("sweep%0d_donecyc", i), dc, recs[i].expCyc);
            chk($sformatf("sweep%0d_dones", i), dn, 1);
            chk($sformatf("sweep%0d_busy", i), busyV[0], 0);
            chk($sformatf("sweep%0d_match", i), aMatch, recs[i].expMatch);
            chk($sformatf("sweep%0d_cnt", i), aCnt, recs[i].expCnt);
            chk($sformatf("sweep%0d_first", i), aFirst, recs[i].expFirst);
            chk($sformatf("sweep%0d_table", i), aTable, recs[i].expTable);
            $display("sweep %0d: mode=%0d done@%0d pulses=%0d match=%0b cnt=%0d first=%0d table=%h",
                     i, aMode, dc, dn, aMatch, aCnt, aFirst, aTable);
            repeat (3) @(posedge clk);
            #1;
            chk($sformatf("sweep%0d_hold", i), aTable, recs[i].expTable);
        end

        // abort in SETTLE while vec=7: samples 0..6 kept, no done
        aMode = 2;
        startV[0] = 1'b1;
        @(posedge clk); #1;
        startV[0] = 1'b0;
        for (int i = 0; i < 100 && aVec != 4'd7; i++) begin
            @(posedge clk); #1;
        end
        chk("abortA_reach", aVec, 7);
        abortV[0] = 1'b1;
        @(posedge clk); #1;
        abortV[0] = 1'b0;
        chk("abortA_busy", busyV[0], 0);
        chk("abortA_vec", aVec, 0);
        chk("abortA_cnt", aCnt, 7);
        chk("abortA_match", aMatch, 0);
        chk("abortA_table", aTable, 16'h002A);
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            if (doneV[0]) extra++;
            @(posedge clk); #1;
        end
        chk("abortA_nodone", extra, 0);
        $display("abortA: busy=%0b vec=%0h cnt=%0d table=%h done_pulses=%0d", busyV[0], aVec, aCnt, aTable, extra);

        // abort in SAMPLE (SETTLE=0) at vec=3: that sample is not taken
        startV[1] = 1'b1;
        @(posedge clk); #1;
        startV[1] = 1'b0;
        for (int i = 0; i < 100 && bVec != 4'd3; i++) begin
            @(posedge clk); #1;
        end
        chk("abortB_reach", bVec, 3);
        abortV[1] = 1'b1;
        @(posedge clk); #1;
        abortV[1] = 1'b0;
        chk("abortB_busy", busyV[1], 0);
        chk("abortB_table", bTable, 16'h0004);
        chk("abortB_match", bMatch, 1);
        $display("abortB: busy=%0b vec=%0h table=%h", busyV[1], bVec, bTable);

        // SETTLE=0 sweep with mismatches at 5 and 11
        @(negedge clk);
        runSweep(1, 1'b0, 0, 0, dc, dn);
        chk("sweepB_donecyc", dc, 17);
        chk("sweepB_dones", dn, 1);
        chk("sweepB_match", bMatch, 0);
        chk("sweepB_cnt", bCnt, 2);
        chk("sweepB_first", bFirst, 5);
        chk("sweepB_table", bTable, 16'hCCCC);
        $display("sweepB: done@%0d match=%0b cnt=%0d first=%0d table=%h", dc, bMatch, bCnt, bFirst, bTable);

        // N=3, SETTLE=2 with a second start at cycle 6
        @(negedge clk);
        runSweep(2, 1'b0, 6, 0, dc, dn);
        chk("sweepC_donecyc", dc, 25);
        chk("sweepC_dones", dn, 1);
        chk("sweepC_match", cMatch, 1);
        chk("sweepC_cnt", cCnt, 0);
        chk("sweepC_table", cTable, 8'hFF);
        $display("sweepC: done@%0d pulses=%0d match=%0b table=%h", dc, dn, cMatch, cTable);

        // reset mid-sweep at vec=9, then an immediate full sweep
        aMode = 1;
        @(negedge clk);
        startV[0] = 1'b1;
        @(posedge clk); #1;
        startV[0] = 1'b0;
        for (int i = 0; i < 100 && aVec != 4'd9; i++) begin
            @(posedge clk); #1;
        end
        chk("rstmid_reach", aVec, 9);
        #2;
        rstnV[0] = 1'b0;
        #1;
        chk("rstmid_busy", busyV[0], 0);
        chk("rstmid_vec", aVec, 0);
        chk("rstmid_done", doneV[0], 0);
        chk("rstmid_match", aMatch, 1);
        chk("rstmid_cnt", aCnt, 0);
        chk("rstmid_table", aTable, 0);
        $display("rstmid: busy=%0b vec=%0h match=%0b table=%h", busyV[0], aVec, aMatch, aTable);
        @(negedge clk);
        rstnV[0] = 1'b1;
        runSweep(0, 1'b0, 0, 0, dc, dn);
        chk("rstmid_donecyc", dc, 33);
        chk("rstmid_dones", dn, 1);
        chk("rstmid_match2", aMatch, 1);
        chk("rstmid_table2", aTable, 16'hFFFF);
        $display("rstmid sweep: done@%0d match=%0b table=%h", dc, aMatch, aTable);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
